// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: load/store size codes and FSM state type for the data memory
package riscv_mem_pkg;
    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;
    typedef enum logic [1:0] {IDLE, WAIT, DONE} mem_state_t;
endpackage

// File: rtl/byte_ram.sv
// byte_ram: DEPTH x 32 word RAM with byte-enable write and synchronous read
module byte_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          i_we,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wd,
    input  logic          i_re,
    output logic [31:0]   o_rd
);
    logic [31:0] r_mem [DEPTH];
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++)
            if (i_we && i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wd[8*b +: 8];
        if (i_re) o_rd <= r_mem[i_addr];
    end
endmodule

// File: rtl/riscv_data_mem.sv
// riscv_data_mem: fixed-latency load/store responder with lane steering and extension
module riscv_data_mem
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [2:0]  mem_size_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wd_i,
    output logic [31:0] mem_rd_o,
    output logic        stall_o,
    output logic        misalign_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] LAT = 4'(LATENCY);
    mem_state_t  r_state, w_state_nx;
    logic [3:0]  r_cnt, w_cnt_nx;
    logic [31:0] r_hold, w_ram_rd, w_sh, w_ext, w_wdata;
    logic [3:0]  w_be;
    logic        w_byte, w_half, w_mis, w_done, w_unused_addr;
    assign w_unused_addr = &{1'b0, mem_addr_i[31:AW+2]};
    assign w_byte = (mem_size_i == LDST_B) || (mem_size_i == LDST_BU);
    assign w_half = (mem_size_i == LDST_H) || (mem_size_i == LDST_HU);
    assign w_mis  = (w_half & mem_addr_i[0]) | (~w_byte & ~w_half & |mem_addr_i[1:0]);
    assign w_done = r_state == DONE;
    assign w_be = w_byte ? 4'b0001 << mem_addr_i[1:0]
                : w_half ? (mem_addr_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign w_wdata = w_byte ? {4{mem_wd_i[7:0]}} : w_half ? {2{mem_wd_i[15:0]}} : mem_wd_i;
    assign w_sh = w_ram_rd >> {mem_addr_i[1:0], 3'b000};
    // size bit 2 marks the unsigned variants; illegal codes already decode as word
    assign w_ext = w_mis  ? 32'd0
                 : w_byte ? {{24{~mem_size_i[2] & w_sh[7]}}, w_sh[7:0]}
                 : w_half ? {{16{~mem_size_i[2] & w_sh[15]}}, w_sh[15:0]} : w_ram_rd;
    assign stall_o    = rst_ni & mem_req_i & ~w_done;
    assign mem_rd_o   = w_done ? w_ext : r_hold;
    assign misalign_o = w_done & w_mis;
    // the IDLE cycle is the first stall cycle, so WAIT covers the remaining LATENCY-1
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        unique case (r_state)
            IDLE: begin
                w_state_nx = mem_req_i ? ((LAT == 4'd1) ? DONE : WAIT) : IDLE;
                w_cnt_nx   = mem_req_i ? 4'd1 : 4'd0;
            end
            WAIT: begin
                w_state_nx = !mem_req_i ? IDLE : (r_cnt + 4'd1 >= LAT) ? DONE : WAIT;
                w_cnt_nx   = mem_req_i ? r_cnt + 4'd1 : 4'd0;
            end
            default: begin
                w_state_nx = IDLE;
                w_cnt_nx   = 4'd0;
            end
        endcase
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_hold  <= 32'd0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            if (w_done) r_hold <= w_ext;
        end
    end
    byte_ram #(.DEPTH(DEPTH)) u_ram (
        .clk_i  (clk_i),
        .i_we   (w_done & mem_we_i & ~w_mis),
        .i_be   (w_be),
        .i_addr (mem_addr_i[AW+1:2]),
        .i_wd   (w_wdata),
        .i_re   (w_state_nx == DONE),
        .o_rd   (w_ram_rd)
    );
endmodule

// File: tb/tb_riscv_data_mem.sv
// tb_riscv_data_mem: directed and random load/store checks against a byte-array memory model
module tb_riscv_data_mem;
    import riscv_mem_pkg::*;
    localparam int DEPTH = 1024;
    localparam int LAT   = 2;
    localparam int MB    = 4 * DEPTH;
    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req = 1'b0, we = 1'b0;
    logic [2:0]  sz = 3'd0;
    logic [31:0] addr = 32'd0, wd = 32'd0;
    logic [31:0] rd_o;
    logic        stall_o, mis_o;
    int          ncmp = 0, nfail = 0;
    logic [7:0]  bm [MB];
    logic [31:0] rd;
    logic        mis;
    riscv_data_mem #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .mem_req_i  (req),
        .mem_we_i   (we),
        .mem_size_i (sz),
        .mem_addr_i (addr),
        .mem_wd_i   (wd),
        .mem_rd_o   (rd_o),
        .stall_o    (stall_o),
        .misalign_o (mis_o)
    );
    always #5 clk = ~clk;
    function automatic int nb(input logic [2:0] s);
        return (s == LDST_B || s == LDST_BU) ? 1 : (s == LDST_H || s == LDST_HU) ? 2 : 4;
    endfunction
    function automatic logic mis_m(input logic [2:0] s, input logic [31:0] a);
        return (nb(s) == 2 && a[0]) || (nb(s) == 4 && a[1:0] != 2'd0);
    endfunction
    function automatic int bidx(input logic [31:0] a, input int i);
        return int'((a + 32'(i)) % 32'(MB));
    endfunction
    function automatic logic [31:0] load_m(input logic [2:0] s, input logic [31:0] a);
        logic [31:0] v = 32'd0;
        if (mis_m(s, a)) return 32'd0;
        for (int i = 0; i < nb(s); i++) v[8*i +: 8] = bm[bidx(a, i)];
        if (s == LDST_B) v = {{24{v[7]}}, v[7:0]};
        if (s == LDST_H) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic idle();
        req = 1'b0;
        @(posedge clk); #1;
    endtask
    // starts one cycle after a posedge, returns one cycle after the edge that ends DONE
    task automatic op(input logic w, input logic [2:0] s, input logic [31:0] a,
                      input logic [31:0] d, input string tag,
                      output logic [31:0] r, output logic m);
        logic [31:0] erd;
        logic        emis;
        int          st = 0;
        bit          done = 0;
        emis = mis_m(s, a);
        erd  = load_m(s, a);
        r = 32'd0; m = 1'b0;
        req = 1'b1; we = w; sz = s; addr = a; wd = d;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (stall_o) st++;
            else begin
                r = rd_o; m = mis_o; done = 1;
            end
        end
        chk({tag, " done"}, 32'(done), 32'd1);
        chk({tag, " stalls"}, st, LAT);
        chk({tag, " misalign"}, 32'(m), 32'(emis));
        if (!w) chk({tag, " rdata"}, r, erd);
        if (w && !emis) for (int i = 0; i < nb(s); i++) bm[bidx(a, i)] = d[8*i +: 8];
        @(posedge clk); #1;
    endtask
    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk) rst_ni = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("reset stall", 32'(stall_o), 32'd0);
            chk("reset rdata", rd_o, 32'd0);
            chk("reset misalign", 32'(mis_o), 32'd0);
        end
        @(posedge clk); #1;
        op(1, LDST_W, 32'h10, 32'hDEADBEEF, "SW 0x10", rd, mis);
        idle();
        op(0, LDST_W, 32'h10, 32'h0, "LW 0x10", rd, mis);
        chk("LW 0x10 const", rd, 32'hDEADBEEF);
        op(1, LDST_B, 32'h13, 32'h80, "SB 0x13", rd, mis);
        op(0, LDST_B, 32'h13, 32'h0, "LB 0x13", rd, mis);
        chk("LB 0x13 const", rd, 32'hFFFFFF80);
        op(0, LDST_BU, 32'h13, 32'h0, "LBU 0x13", rd, mis);
        chk("LBU 0x13 const", rd, 32'h00000080);
        op(0, LDST_W, 32'h10, 32'h0, "LW 0x10 b", rd, mis);
        chk("LW after SB const", rd, 32'h80ADBEEF);
        op(1, LDST_H, 32'h12, 32'hFFFF1234, "SH 0x12", rd, mis);
        op(0, LDST_HU, 32'h12, 32'h0, "LHU 0x12", rd, mis);
        chk("LHU 0x12 const", rd, 32'h00001234);
        op(1, LDST_W, 32'h14, 32'h55AA55AA, "SW 0x14", rd, mis);
        op(0, LDST_W, 32'h11, 32'h0, "LW 0x11", rd, mis);
        chk("LW 0x11 mis const", {31'd0, mis}, 32'd1);
        chk("LW 0x11 rd const", rd, 32'd0);
        idle();
        chk("misalign single pulse", 32'(mis_o), 32'd0);
        op(1, LDST_H, 32'h15, 32'h0000FFFF, "SH 0x15", rd, mis);
        chk("SH 0x15 mis const", {31'd0, mis}, 32'd1);
        idle();
        op(0, LDST_W, 32'h10, 32'h0, "b2b LW 0x10", rd, mis);
        chk("b2b first const", rd, 32'h1234BEEF);
        op(0, LDST_W, 32'h14, 32'h0, "b2b LW 0x14", rd, mis);
        chk("word 0x14 unchanged", rd, 32'h55AA55AA);
        req = 1'b0;
        @(negedge clk);
        chk("rdata held", rd_o, 32'h55AA55AA);
        @(posedge clk); #1;
        req = 1'b1; we = 1'b1; sz = LDST_W; addr = 32'h14; wd = 32'h11111111;
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        chk("abort stall", 32'(stall_o), 32'd0);
        @(posedge clk); #1;
        op(0, LDST_W, 32'h14, 32'h0, "after abort", rd, mis);
        chk("abort no write", rd, 32'h55AA55AA);
        op(1, LDST_W, 32'h1008, 32'hCAFEF00D, "SW wrap", rd, mis);
        op(0, LDST_W, 32'h8, 32'h0, "LW 0x8", rd, mis);
        chk("wrap const", rd, 32'hCAFEF00D);
        req = 1'b1; we = 1'b1; sz = LDST_W; addr = 32'h14; wd = 32'h77777777;
        @(posedge clk); #2;
        rst_ni = 1'b0;
        #1;
        chk("async reset stall", 32'(stall_o), 32'd0);
        repeat (2) @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk) rst_ni = 1'b1;
        @(posedge clk); #1;
        op(0, LDST_W, 32'h14, 32'h0, "after reset", rd, mis);
        chk("reset no write", rd, 32'h55AA55AA);
        for (int i = 0; i < 16; i++) op(1, LDST_W, 32'(4 * i), $urandom(), "init", rd, mis);
        for (int i = 0; i < 80; i++) begin
            op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
               ($urandom() & 32'hFFFF_F000) | 32'($urandom_range(0, 63)), $urandom(),
               "rand", rd, mis);
            if ($urandom_range(0, 1) == 1) idle();
        end
        idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
